// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 codes, FSM states,
// default data-memory depth and the request legality check.
package mem_lsu_pkg;

  localparam int MEM_AW_DEF = 10;

  localparam logic [2:0] F3_B  = 3'd0;  // LB / SB
  localparam logic [2:0] F3_H  = 3'd1;  // LH / SH
  localparam logic [2:0] F3_W  = 3'd2;  // LW / SW
  localparam logic [2:0] F3_BU = 3'd4;  // LBU
  localparam logic [2:0] F3_HU = 3'd5;  // LHU

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_e;

  typedef struct packed {
    logic        load;
    logic [2:0]  f3;
    logic [1:0]  lane;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } lsu_req_t;

  // Illegal funct3 or misaligned access; such requests never touch memory.
  function automatic logic req_bad(logic load, logic [2:0] f3, logic [1:0] lane);
    logic ill, mis;
    ill = load ? (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) : (f3 >= 3'd3);
    mis = (f3[1:0] == 2'd1 && lane[0]) || (f3[1:0] == 2'd2 && lane != 2'd0);
    return ill | mis;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// EX request, data-memory and WB response bundle of the load/store unit.
interface mem_lsu_if
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = MEM_AW_DEF
);
  logic              req_valid, req_ready, req_load;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              mem_rd_en, mem_wr_en;
  logic [MEM_AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [31:0]       mem_rd_data, mem_wr_data;
  logic              rsp_valid, rsp_ready, rsp_wb, rsp_err;
  logic [4:0]        rsp_rd;
  logic [31:0]       rsp_data;

  modport slave (
    input  req_valid, req_load, req_funct3, req_addr, req_wdata, req_rd, mem_rd_data, rsp_ready,
    output req_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
           rsp_valid, rsp_wb, rsp_rd, rsp_data, rsp_err
  );
  modport master (
    output req_valid, req_load, req_funct3, req_addr, req_wdata, req_rd, mem_rd_data, rsp_ready,
    input  req_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
           rsp_valid, rsp_wb, rsp_rd, rsp_data, rsp_err
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Load extract/extend and sub-word store merge into the previously read word.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'd0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'd0, w_half};
      default: o_load = i_rdata;
    endcase
    o_store = i_rdata;
    case (i_funct3)
      F3_B:    o_store[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      F3_H:    o_store[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_store = i_wdata;
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one request in flight, RMW for SB/SH because the
// data memory has no byte strobes.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic      clk,
  input  logic      rst,
  mem_lsu_if.slave  bus
);
  lsu_state_e        r_state;
  lsu_req_t          r_req;
  logic [MEM_AW-1:0] r_widx;
  logic [DATA_W-1:0] r_wword, r_rdata;
  logic              r_err, r_wb;

  logic [ADDR_W-1:0] w_addr;
  logic              w_bad, w_unused;
  logic [31:0]       w_load, w_store;
  logic              w_rd, w_wr, w_resp;

  assign w_addr   = bus.req_addr;
  assign w_unused = ^w_addr[ADDR_W-1:MEM_AW+2];
  assign w_bad    = req_bad(bus.req_load, bus.req_funct3, w_addr[1:0]);

  lsu_align u_align (
    .i_funct3 (r_req.f3),
    .i_lane   (r_req.lane),
    .i_rdata  (bus.mem_rd_data),
    .i_wdata  (r_req.wdata),
    .o_load   (w_load),
    .o_store  (w_store)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
      r_widx  <= '0;
      r_wword <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_wb    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.req_valid) begin
          r_req   <= '{load: bus.req_load, f3: bus.req_funct3, lane: w_addr[1:0],
                       wdata: bus.req_wdata, rd: bus.req_rd};
          r_widx  <= w_addr[MEM_AW+1:2];
          r_wword <= bus.req_wdata;
          r_rdata <= '0;
          r_err   <= w_bad;
          r_wb    <= 1'b0;
          if (w_bad)                                      r_state <= ST_RESP;
          else if (!bus.req_load && bus.req_funct3 == F3_W) r_state <= ST_WR;
          else                                            r_state <= ST_RD;
        end
        ST_RD:  r_state <= ST_CAP;
        ST_CAP: if (r_req.load) begin
          r_rdata <= w_load;
          r_wb    <= 1'b1;
          r_state <= ST_RESP;
        end else begin
          r_wword <= w_store;
          r_state <= ST_WR;
        end
        ST_WR:   r_state <= ST_RESP;
        ST_RESP: if (bus.rsp_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Everything is forced low while rst is high, even before the registers clear.
  assign w_rd   = !rst && r_state == ST_RD;
  assign w_wr   = !rst && r_state == ST_WR;
  assign w_resp = !rst && r_state == ST_RESP;

  assign bus.req_ready   = !rst && r_state == ST_IDLE;
  assign bus.mem_rd_en   = w_rd;
  assign bus.mem_rd_addr = w_rd ? r_widx : '0;
  assign bus.mem_wr_en   = w_wr;
  assign bus.mem_wr_addr = w_wr ? r_widx : '0;
  assign bus.mem_wr_data = w_wr ? r_wword : '0;
  assign bus.rsp_valid   = w_resp;
  assign bus.rsp_wb      = w_resp & r_wb;
  assign bus.rsp_err     = w_resp & r_err;
  assign bus.rsp_rd      = w_resp ? r_req.rd : '0;
  assign bus.rsp_data    = w_resp ? r_rdata : '0;
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, reset/backpressure sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_mem_lsu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_lsu_if #(.ADDR_W(32), .MEM_AW(10)) bus ();
  mem_lsu #(.ADDR_W(32), .DATA_W(32), .MEM_AW(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  int n_cmp = 0, n_bad = 0;
  int rd_cnt = 0, wr_cnt = 0;
  logic [9:0]  last_wa;
  logic [31:0] last_wd;

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      mem[bus.mem_wr_addr] <= bus.mem_wr_data;
      last_wa <= bus.mem_wr_addr;
      last_wd <= bus.mem_wr_data;
      wr_cnt  <= wr_cnt + 1;
    end
    if (bus.mem_rd_en) begin
      bus.mem_rd_data <= mem[bus.mem_rd_addr];
      rd_cnt <= rd_cnt + 1;
    end
    n_cmp <= n_cmp + 1;
    if (bus.mem_rd_en && bus.mem_wr_en) begin
      n_bad <= n_bad + 1;
      $display("FAIL both_enables: rd_en=1 wr_en=1 at %0t, required not both", $time);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: size/sign rules plus shift-and-mask arithmetic on a shadow memory.
  task automatic model(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] data, output bit err,
                       output int lat, output int nrd, output int nwr, output logic [31:0] wword);
    int sz; bit uns, ill; int idx, sh; longint m, v, w;
    sz = 4; uns = 0; ill = 0;
    if (ld) case (f3)
      0: sz = 1; 1: sz = 2; 2: sz = 4; 4: begin sz = 1; uns = 1; end
      5: begin sz = 2; uns = 1; end default: ill = 1;
    endcase else case (f3)
      0: sz = 1; 1: sz = 2; 2: sz = 4; default: ill = 1;
    endcase
    err = ill || (addr % sz != 0);
    idx = (addr / 4) % 1024; sh = (addr % 4) * 8;
    m = (64'd1 << (8 * sz)) - 1;
    w = ref_mem[idx];
    data = 0; wword = 0; nrd = 0; nwr = 0; lat = 1;
    if (err) return;
    if (ld) begin
      v = (w >> sh) & m;
      if (!uns && sz < 4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
      data = v[31:0]; lat = 3; nrd = 1;
    end else begin
      v = (w & ~(m << sh)) | ((longint'(wd) & m) << sh);
      wword = v[31:0]; ref_mem[idx] = wword;
      lat = (sz == 4) ? 2 : 4; nrd = (sz == 4) ? 0 : 1; nwr = 1;
    end
  endtask

  task automatic do_req(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] e_data, input bit e_err, input int e_lat,
                        input int e_nrd, input int e_nwr, input logic [31:0] e_wword,
                        input int hold, input string tag);
    int k, r0, w0;
    bit e_wb;
    e_wb = ld && !e_err;
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    r0 = rd_cnt; w0 = wr_cnt;
    bus.req_valid = 1; bus.req_load = ld; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd; bus.req_rd = rd; bus.rsp_ready = 0;
    @(negedge clk);
    bus.req_valid = 0;
    k = 1;
    while (!bus.rsp_valid && k < 20) begin @(negedge clk); k++; end
    chk({tag, ".latency"}, 32'(k), 32'(e_lat));
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, ".rsp_data"}, bus.rsp_data, e_data);
      chk({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(e_err));
      chk({tag, ".rsp_wb"}, 32'(bus.rsp_wb), 32'(e_wb));
      if (e_wb) chk({tag, ".rsp_rd"}, 32'(bus.rsp_rd), 32'(rd));
      if (hold > 0) chk({tag, ".busy_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1;
    @(negedge clk);
    bus.rsp_ready = 0;
    chk({tag, ".idle_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".idle_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".n_rd"}, 32'(rd_cnt - r0), 32'(e_nrd));
    chk({tag, ".n_wr"}, 32'(wr_cnt - w0), 32'(e_nwr));
    if (e_nwr > 0) begin
      chk({tag, ".wr_addr"}, 32'(last_wa), 32'(addr[11:2]));
      chk({tag, ".wr_data"}, last_wd, e_wword);
    end
  endtask

  typedef struct {
    bit ld; logic [2:0] f3; logic [31:0] addr, wd;
    logic [31:0] e_data; bit e_err; int e_lat, e_nrd, e_nwr; logic [31:0] e_wword; int hold;
  } vec_t;

  vec_t tbl[14];
  logic [31:0] m_data, m_ww;
  bit m_err; int m_lat, m_nrd, m_nwr;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    mem[10'h40] = 32'h8899AABB;
    tbl[0]  = '{1, 3'd0, 32'h101, 0, 32'hFFFFFFAA, 0, 3, 1, 0, 0, 5};
    tbl[1]  = '{1, 3'd4, 32'h101, 0, 32'h000000AA, 0, 3, 1, 0, 0, 0};
    tbl[2]  = '{1, 3'd1, 32'h102, 0, 32'hFFFF8899, 0, 3, 1, 0, 0, 0};
    tbl[3]  = '{1, 3'd5, 32'h102, 0, 32'h00008899, 0, 3, 1, 0, 0, 0};
    tbl[4]  = '{1, 3'd2, 32'h100, 0, 32'h8899AABB, 0, 3, 1, 0, 0, 0};
    tbl[5]  = '{0, 3'd2, 32'h100, 32'h12345678, 0, 0, 2, 0, 1, 32'h12345678, 0};
    tbl[6]  = '{0, 3'd0, 32'h102, 32'hAAAAAAEE, 0, 0, 4, 1, 1, 32'h12EE5678, 0};
    tbl[7]  = '{0, 3'd1, 32'h100, 32'h5555BEEF, 0, 0, 4, 1, 1, 32'h12EEBEEF, 3};
    tbl[8]  = '{1, 3'd2, 32'h80000100, 0, 32'h12EEBEEF, 0, 3, 1, 0, 0, 0};
    tbl[9]  = '{1, 3'd2, 32'h102, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[10] = '{0, 3'd1, 32'h103, 32'hFFFF, 0, 1, 1, 0, 0, 0, 2};
    tbl[11] = '{1, 3'd3, 32'h100, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[12] = '{0, 3'd4, 32'h100, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[13] = '{1, 3'd0, 32'h0000_0FFF, 0, 32'(32'($signed(mem[10'h3FF][31:24]))), 0, 3, 1, 0, 0, 0};

    rst = 1;
    bus.req_valid = 0; bus.req_load = 0; bus.req_funct3 = 0; bus.req_addr = 0;
    bus.req_wdata = 0; bus.req_rd = 0; bus.rsp_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst.outputs", {bus.mem_rd_en, bus.mem_wr_en, bus.rsp_valid, bus.rsp_err, bus.rsp_wb},
        32'd0);
    rst = 0;
    @(negedge clk);
    chk("post_rst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst.rsp_data", bus.rsp_data, 32'd0);
    chk("post_rst.wr_data", bus.mem_wr_data, 32'd0);

    for (int i = 0; i < 14; i++)
      do_req(tbl[i].ld, tbl[i].f3, tbl[i].addr, tbl[i].wd, 5'(i + 1), tbl[i].e_data,
             tbl[i].e_err, tbl[i].e_lat, tbl[i].e_nrd, tbl[i].e_nwr, tbl[i].e_wword,
             tbl[i].hold, $sformatf("vec%0d", i));
    ref_mem[10'h40] = 32'h12EEBEEF;

    // Reset landing in the CAP cycle of an SB must suppress the write.
    begin
      int r0, w0;
      @(negedge clk);
      r0 = rd_cnt; w0 = wr_cnt;
      bus.req_valid = 1; bus.req_load = 0; bus.req_funct3 = 3'd0;
      bus.req_addr = 32'h102; bus.req_wdata = 32'h55;
      @(negedge clk); bus.req_valid = 0;
      @(negedge clk);
      rst = 1; #1;
      chk("rstcap.req_ready", 32'(bus.req_ready), 32'd0);
      chk("rstcap.enables", {bus.mem_rd_en, bus.mem_wr_en, bus.rsp_valid}, 32'd0);
      chk("rstcap.rsp_data", bus.rsp_data, 32'd0);
      @(negedge clk); rst = 0; #1;
      chk("rstcap.after_ready", 32'(bus.req_ready), 32'd1);
      repeat (4) @(negedge clk);
      chk("rstcap.n_wr", 32'(wr_cnt - w0), 32'd0);
      chk("rstcap.n_rd", 32'(rd_cnt - r0), 32'd1);
      chk("rstcap.mem", mem[10'h40], 32'h12EEBEEF);
    end

    for (int i = 0; i < 80; i++) begin
      bit ld; logic [2:0] f3; logic [31:0] a, wd; logic [4:0] rd;
      ld = 1'($urandom); f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      a = {$urandom_range(0, 3) == 0 ? 20'($urandom) : 20'd0, 12'h100 + 12'($urandom_range(0, 31))};
      wd = $urandom; rd = 5'($urandom);
      model(ld, f3, a, wd, m_data, m_err, m_lat, m_nrd, m_nwr, m_ww);
      do_req(ld, f3, a, wd, rd, m_data, m_err, m_lat, m_nrd, m_nwr, m_ww,
             $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the RV32I core's MEM stage, sitting directly upstream of the word-addressed data memory. It accepts one load or store per handshake from EX, performs alignment checks, and drives the memory's separate read and write ports. It extracts and sign- or zero-extends load data. Because the memory has no byte strobes, it implements SB/SH as a read-modify-write. Every request returns exactly one response toward writeback.

## Interface
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: data width; fixed at 32 (RV32).
- `MEM_AW`, 10: word-index width driven to data memory.

- `clk`  in  1  core clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  EX request valid.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_load`  in  1  1 = load, 0 = store.
- `req_funct3`  in  3  RV32I funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, rs2.
- `req_rd`  in  5  load destination register.
- `mem_rd_en`  out  1  data-memory read enable.
- `mem_rd_addr`  out  MEM_AW  read word index, `addr[MEM_AW+1:2]`.
- `mem_rd_data`  in  32  read word; valid the cycle after `mem_rd_en`.
- `mem_wr_en`  out  1  data-memory write enable.
- `mem_wr_addr`  out  MEM_AW  write word index.
- `mem_wr_data`  out  32  full word to write.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  WB accepts response.
- `rsp_wb`  out  1  1 = write `rsp_data` to `rsp_rd` (loads without error).
- `rsp_rd`  out  5  destination register.
- `rsp_data`  out  32  extended load result; 0 for stores and errors.
- `rsp_err`  out  1  misaligned address or illegal funct3; no memory access was made.

## Operation
- FSM states: `IDLE`, `RD`, `CAP`, `WR`, `RESP`.
- **IDLE**
  - `req_ready=1`.
  - On accept, register the request; word index is `req_addr[MEM_AW+1:2]`, lane is `req_addr[1:0]`.
  - Error cases go to `RESP` with `rsp_err=1`:
    - illegal funct3: loads 3/6/7, stores ≥3;
    - misaligned: halfword with `addr[0]=1`, word with `addr[1:0]≠0`.
  - Otherwise loads and SB/SH go to `RD`; SW goes to `WR` with `mem_wr_data = wdata`.
- **RD**: `mem_rd_en=1` for exactly one cycle, then go to `CAP`.
- **CAP**: sample `mem_rd_data`.
  - Load: extract and extend, then go to `RESP`.
    - LB/LBU: byte at lane×8.
    - LH/LHU: halfword at `addr[1]`×16.
    - LW: whole word.
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - Store: merge the new byte or halfword into the read word, keep the other bytes unchanged, then go to `WR`.
- **WR**: `mem_wr_en=1` for one cycle with the registered word index and word, then go to `RESP`.
- **RESP**: `rsp_valid=1`, outputs stable; on `rsp_ready`, return to `IDLE`.
- Only one request is in flight; `req_ready=0` in every state except `IDLE`.
- Stores respond with `rsp_wb=0`, `rsp_data=0`.
- Word index truncates silently to `MEM_AW` bits; upper address bits are ignored.

## Timing
- Accept at edge of cycle A. First cycle that `rsp_valid` can be high:
  - error: A+1
  - SW: A+2
  - load: A+3
  - SB/SH: A+4
- `rsp_valid` stays high until the cycle `rsp_ready` is seen. The next request can be accepted the cycle after that handshake.
- `mem_rd_en` and `mem_wr_en` are decoded from the state and gated with `!rst`.
  - Never both high in the same cycle.
  - Each pulses exactly once per applicable request.
- Reset, including mid-operation: next state is `IDLE`, and the in-flight request is dropped.
  - No memory write occurs in the reset cycle or afterwards.
  - All outputs are 0 while `rst` is high.
  - After reset, `req_ready=1` and all other outputs are 0.

## Structure
- Shared defines header (the core's `define` file) holds:
  - funct3 load/store encodings;
  - FSM state encoding;
  - `MEM_AW` default, matching the data-memory depth.
- One combinational sub-module, `lsu_align`, handles load extract/extend and store merge: inputs funct3, lane, read word, store data.
- `mem_lsu` holds the FSM and request/response registers.

## Test plan
- Memory word 0x40 holds 0x8899AABB; LB at addr 0x101 → `rsp_data=0xFFFFFFAA`, `rsp_wb=1`, `rsp_valid` at A+3; LBU at the same addr → `0x000000AA`.
- SW of 0x12345678 at 0x100 → single `mem_wr_en` at A+1 with word index 0x40 and data 0x12345678; no `mem_rd_en`; `rsp_wb=0`.
- Word 0x40 holds 0x12345678; SB of 0xEE at 0x102, then SH of 0xBEEF at 0x100 → written words 0x12EE5678, then 0x12EEBEEF; each store gives one read and one write.
- LW at 0x102 and SH at 0x103 → `rsp_err=1` at A+1; zero memory enables; `rsp_wb=0`.
- Backpressure: hold `rsp_ready=0` for 5 cycles during a load → response is stable and `req_ready=0` throughout; handshake then returns to `IDLE`.
- Assert `rst` in the `CAP` cycle of an SB → no `mem_wr_en` is ever seen; outputs are 0; `req_ready=1` the cycle after reset.
